fifo_burst_writer: RTL and testbench
====================================

# fifo_burst_writer

Write-side burst packer that sits directly upstream of the async FIFO in the write clock domain. It collects a valid/ready word stream into a local burst buffer. Once it has checked free space against the FIFO's write-side fill level, it drives the FIFO write port with one contiguous write-enable burst. Each burst is followed by a mandatory low gap, because the FIFO publishes its write pointer on the falling edge of its write enable.

## Interface
- WIDTH, 8, data word width; must equal the FIFO's WIDTH.
- PTRWIDTH, 4, FIFO address width; FIFO depth = 2^PTRWIDTH.
- BURST_LEN, 4, maximum words per burst; legal range 1..2^PTRWIDTH.
- TIMEOUT, 16, idle cycles before a partial burst is flushed (used only with the macro).

Ports (reset wr_rst_n, asynchronous, active-low; clock wr_clk):
- wr_clk  in  1  write-domain clock
- wr_rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  upstream word valid
- s_ready  out  1  upstream ready; high only in FILL with fewer than BURST_LEN words buffered
- s_data  in  WIDTH  upstream word
- s_last  in  1  marks the final word of a packet; closes the burst
- fifo_wr_en  out  1  FIFO write enable (registered)
- fifo_data  out  WIDTH  FIFO write data (registered)
- fifo_wr_usedw  in  PTRWIDTH+1  FIFO write-side fill level
- fifo_full  in  1  FIFO full flag
- burst_done  out  1  one-cycle pulse in the final DRAIN cycle
- bursts_sent  out  16  count of completed bursts; wraps modulo 2^16

## Operation
- FSM states: IDLE, FILL, WAIT_SPACE, DRAIN, GAP.
- IDLE
  - Entered on reset.
  - Moves unconditionally to FILL on the next clock.
- FILL
  - A word is accepted when s_valid && s_ready; it is stored at buf[fill_cnt], then fill_cnt++.
  - fill_cnt width is clog2(BURST_LEN)+1.
  - The burst closes on the accepting edge when the new fill_cnt == BURST_LEN or s_last=1. The FSM then goes to WAIT_SPACE.
- WAIT_SPACE
  - free = 2^PTRWIDTH − fifo_wr_usedw, computed in PTRWIDTH+2 bits without wrap.
  - Moves to DRAIN when free >= fill_cnt and fifo_full=0; otherwise it holds indefinitely.
- DRAIN
  - Asserts fifo_wr_en for exactly fill_cnt consecutive cycles.
  - fifo_data = buf[0], buf[1], … in acceptance order.
  - burst_done pulses in the last DRAIN cycle.
  - bursts_sent increments on the DRAIN→GAP edge.
- GAP
  - fifo_wr_en=0 for exactly 2 cycles. This guarantees a falling edge, so the FIFO commits its pointer and wr_usedw settles before the next space check.
  - Then clears fill_cnt and goes to FILL.
- There is no mid-burst pause. The space check guarantees that no write is dropped, so fifo_full must never be high while fifo_wr_en=1.
- Upstream backpressure: s_ready=0 in IDLE, WAIT_SPACE, DRAIN and GAP.
- Reset mid-operation aborts the burst immediately. Buffered words are discarded, the outputs go to their reset values, and the FSM enters IDLE.

## Timing
- Reset values: s_ready=0, fifo_wr_en=0, fifo_data=0, burst_done=0, bursts_sent=0, fill_cnt=0, state=IDLE.
- s_ready first rises one cycle after wr_rst_n deasserts.
- Latency from the closing accepted word to the first fifo_wr_en, when space is available: 2 cycles. Edge 1 enters WAIT_SPACE; edge 2 enters DRAIN and registers fifo_wr_en=1 with buf[0].
- Burst of N words: fifo_wr_en high N cycles, then low at least 2 cycles.
- Minimum period per full burst: 1 (closing word) + 1 (WAIT_SPACE) + BURST_LEN + 2 (GAP) cycles, plus BURST_LEN−1 fill cycles.
- Boundary cases:
  - When fifo_wr_usedw == 2^PTRWIDTH, free=0 and the FSM stays in WAIT_SPACE.
  - When free == fill_cnt exactly, DRAIN proceeds.
  - s_last on the BURST_LEN-th word closes the burst once, not twice.

## Configuration
- Macro FIFO_BURST_TIMEOUT_EN.
- Defined:
  - In FILL with fill_cnt>0, a counter increments every cycle without an accepted word and clears on each accept.
  - When the counter reaches TIMEOUT, the partial burst closes and the FSM goes to WAIT_SPACE.
- Undefined: no counter is built; a partial burst closes only on s_last or at BURST_LEN.

## Test plan
- Reset then 4 words 0x11..0x44 with no s_last, BURST_LEN=4, FIFO empty -> fifo_wr_en high 4 cycles carrying 0x11,0x22,0x33,0x44, starting 2 cycles after the 4th accept; burst_done pulses once; bursts_sent=1.
- 2 words 0xA0,0xA1 with s_last on 0xA1 -> a 2-cycle burst, then fifo_wr_en low 2 cycles, then s_ready=1.
- fifo_wr_usedw=14 (depth 16), 4 buffered words -> hold in WAIT_SPACE with s_ready=0; drop usedw to 12 -> burst of 4 issued.
- Continuous s_valid, 3 bursts -> every burst is separated by ≥2 low cycles of fifo_wr_en; no word is lost or reordered; fifo_full is never high while fifo_wr_en=1.
- wr_rst_n pulsed low during the 2nd DRAIN cycle -> fifo_wr_en=0 immediately; after release, the next burst contains only new data.
- With FIFO_BURST_TIMEOUT_EN and TIMEOUT=16, 1 word 0x5A then idle -> a 1-word burst issued 16 idle cycles plus 2 cycles later. Without the macro -> no write.

Source files
------------

// File: rtl/fifo_burst_writer.sv
// Write-side burst packer feeding an async FIFO write port.
// Optional idle flush of partial bursts: define FIFO_BURST_TIMEOUT_EN.
module fifo_burst_writer #(
  parameter int WIDTH     = 8,
  parameter int PTRWIDTH  = 4,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                wr_clk,
  input  logic                wr_rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [WIDTH-1:0]    s_data,
  input  logic                s_last,
  output logic                fifo_wr_en,
  output logic [WIDTH-1:0]    fifo_data,
  input  logic [PTRWIDTH:0]   fifo_wr_usedw,
  input  logic                fifo_full,
  output logic                burst_done,
  output logic [15:0]         bursts_sent
);

  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam int IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int FW = PTRWIDTH + 2;
  localparam logic [FW-1:0] DEPTH = FW'(2 ** PTRWIDTH);
  localparam logic [CW-1:0] BLEN  = CW'(BURST_LEN);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WAIT_SPACE,
    DRAIN,
    GAP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] burst_buf [BURST_LEN];
  logic [CW-1:0]    fill_cnt;
  logic [CW-1:0]    fill_nx;
  logic [CW-1:0]    rd_idx;
  logic             gap_cnt;
  logic             accept;
  logic             close_burst;
  logic             space_ok;
  logic             drain_last;
  logic             tmo_hit;
  logic [FW-1:0]    free;

  assign s_ready = (state == FILL) && (fill_cnt < BLEN);
  assign accept  = s_valid && s_ready;
  assign fill_nx = fill_cnt + CW'(1);

  // Top bit set means usedw exceeds depth: treat as no room at all.
  assign free     = DEPTH - {1'b0, fifo_wr_usedw};
  assign space_ok = !free[FW-1]
                 && (free >= FW'(fill_cnt))
                 && !fifo_full;

  assign drain_last = (state == DRAIN) && (rd_idx == fill_cnt);
  assign burst_done = drain_last;

  assign close_burst = (accept && ((fill_nx == BLEN) || s_last))
                    || tmo_hit;

`ifdef FIFO_BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      tmo_cnt <= '0;
    end else if (state != FILL || accept || fill_cnt == '0) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign tmo_hit = (state == FILL)
                && (fill_cnt != '0)
                && !accept
                && (tmo_cnt == TW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:       state_nx = FILL;
      FILL:       if (close_burst) state_nx = WAIT_SPACE;
      WAIT_SPACE: if (space_ok) state_nx = DRAIN;
      DRAIN:      if (drain_last) state_nx = GAP;
      GAP:        if (gap_cnt) state_nx = FILL;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      for (int i = 0; i < BURST_LEN; i++) begin
        burst_buf[i] <= '0;
      end
    end else if (accept) begin
      burst_buf[fill_cnt[IW-1:0]] <= s_data;
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      fill_cnt    <= '0;
      rd_idx      <= '0;
      gap_cnt     <= 1'b0;
      fifo_wr_en  <= 1'b0;
      fifo_data   <= '0;
      bursts_sent <= '0;
    end else begin
      unique case (state)
        FILL: begin
          if (accept) begin
            fill_cnt <= fill_nx;
          end
        end
        WAIT_SPACE: begin
          if (space_ok) begin
            fifo_wr_en <= 1'b1;
            fifo_data  <= burst_buf[0];
            rd_idx     <= CW'(1);
          end
        end
        DRAIN: begin
          if (drain_last) begin
            fifo_wr_en  <= 1'b0;
            gap_cnt     <= 1'b0;
            bursts_sent <= bursts_sent + 16'd1;
          end else begin
            fifo_data <= burst_buf[rd_idx[IW-1:0]];
            rd_idx    <= rd_idx + CW'(1);
          end
        end
        GAP: begin
          gap_cnt <= 1'b1;
          if (gap_cnt) begin
            fill_cnt <= '0;
          end
        end
        default: begin
          fifo_wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Scoreboard bench for fifo_burst_writer: directed bursts,
// space stalls, reset abort, partial-burst idle behaviour.
module tb_fifo_burst_writer;

  logic        wr_clk = 1'b0;
  logic        wr_rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        s_last = 1'b0;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data;
  logic [4:0]  fifo_wr_usedw = '0;
  logic        fifo_full = 1'b0;
  logic        burst_done;
  logic [15:0] bursts_sent;

  int n_tests = 0;
  int n_fail = 0;
  int wr_count = 0;
  int done_cnt = 0;
  int low_run = 100;
  bit prev_en = 1'b0;
  logic [7:0] exp_q[$];

  fifo_burst_writer #(
    .WIDTH(8), .PTRWIDTH(4), .BURST_LEN(4), .TIMEOUT(16)
  ) dut (
    .wr_clk(wr_clk),
    .wr_rst_n(wr_rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .fifo_wr_en(fifo_wr_en),
    .fifo_data(fifo_data),
    .fifo_wr_usedw(fifo_wr_usedw),
    .fifo_full(fifo_full),
    .burst_done(burst_done),
    .bursts_sent(bursts_sent)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    bit ok;
    bit got;
    got = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int i = 0; i < 200; i++) begin
      ok = s_ready;
      step();
      if (ok) begin
        got = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: word %0h never accepted", d);
    end
  endtask

  task automatic wait_ready(input string nm, input int max);
    for (int i = 0; i < max; i++) begin
      if (s_ready) break;
      step();
    end
    chk(nm, 32'(s_ready), 32'd1);
  endtask

  // Scoreboard monitor: every write must match the next expected word.
  always @(negedge wr_clk) begin
    if (!wr_rst_n) begin
      prev_en = 1'b0;
      low_run = 100;
    end else begin
      if (fifo_wr_en) begin
        if (!prev_en) begin
          chk("gap_low_cycles", 32'(low_run >= 2), 32'd1);
        end
        chk("full_during_write", 32'(fifo_full), 32'd0);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got %0h expected none",
                   fifo_data);
        end else begin
          chk("wr_data", 32'(fifo_data), 32'(exp_q.pop_front()));
        end
        wr_count++;
        low_run = 0;
      end else begin
        low_run++;
      end
      if (burst_done) done_cnt++;
      prev_en = fifo_wr_en;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    // reset state
    step();
    step();
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_data", 32'(fifo_data), 32'd0);
    chk("rst_done", 32'(burst_done), 32'd0);
    chk("rst_bursts", 32'(bursts_sent), 32'd0);
    wr_rst_n = 1'b1;
    chk("idle_s_ready", 32'(s_ready), 32'd0);
    step();
    chk("fill_s_ready", 32'(s_ready), 32'd1);

    // T1: full burst of 4, latency 2
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    send(8'h44, 0);
    chk("t1_lat_edge1", 32'(fifo_wr_en), 32'd0);
    chk("t1_ws_ready", 32'(s_ready), 32'd0);
    step();
    chk("t1_lat_edge2", 32'(fifo_wr_en), 32'd1);
    chk("t1_first_word", 32'(fifo_data), 32'h11);
    wait_ready("t1_back_to_fill", 30);
    chk("t1_bursts", 32'(bursts_sent), 32'd1);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_wr_cnt", 32'(wr_count), 32'd4);

    // T2: s_last closes a 2-word burst, then 2-cycle gap
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA1);
    send(8'hA0, 0);
    send(8'hA1, 1);
    chk("t2_ws", 32'(fifo_wr_en), 32'd0);
    step();
    chk("t2_d1_en", 32'(fifo_wr_en), 32'd1);
    chk("t2_d1_done", 32'(burst_done), 32'd0);
    step();
    chk("t2_d2_en", 32'(fifo_wr_en), 32'd1);
    chk("t2_d2_done", 32'(burst_done), 32'd1);
    step();
    chk("t2_g1_en", 32'(fifo_wr_en), 32'd0);
    chk("t2_g1_rdy", 32'(s_ready), 32'd0);
    step();
    chk("t2_g2_en", 32'(fifo_wr_en), 32'd0);
    chk("t2_g2_rdy", 32'(s_ready), 32'd0);
    step();
    chk("t2_fill_rdy", 32'(s_ready), 32'd1);
    chk("t2_bursts", 32'(bursts_sent), 32'd2);

    // T3: no space (usedw 16, 14), exact fit at 12
    fifo_wr_usedw = 5'd16;
    exp_q.push_back(8'hC1);
    exp_q.push_back(8'hC2);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'hC4);
    send(8'hC1, 0);
    send(8'hC2, 0);
    send(8'hC3, 0);
    send(8'hC4, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_hold16_en", 32'(fifo_wr_en), 32'd0);
      chk("t3_hold16_rdy", 32'(s_ready), 32'd0);
    end
    fifo_wr_usedw = 5'd14;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_hold14_en", 32'(fifo_wr_en), 32'd0);
      chk("t3_hold14_rdy", 32'(s_ready), 32'd0);
    end
    fifo_wr_usedw = 5'd12;
    step();
    chk("t3_go_en", 32'(fifo_wr_en), 32'd1);
    chk("t3_go_data", 32'(fifo_data), 32'hC1);
    wait_ready("t3_back_to_fill", 30);
    fifo_wr_usedw = 5'd0;
    chk("t3_bursts", 32'(bursts_sent), 32'd3);

    // T4: continuous stream, 3 bursts
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(8'(8'h60 + i));
    end
    for (int i = 0; i < 12; i++) begin
      send(8'(8'h60 + i), 0);
    end
    wait_ready("t4_back_to_fill", 40);
    chk("t4_bursts", 32'(bursts_sent), 32'd6);
    chk("t4_wr_cnt", 32'(wr_count), 32'd22);

    // T5: reset during the 2nd DRAIN cycle
    exp_q.push_back(8'h71);
    send(8'h71, 0);
    send(8'h72, 0);
    send(8'h73, 0);
    send(8'h74, 0);
    step();
    chk("t5_d1_en", 32'(fifo_wr_en), 32'd1);
    step();
    wr_rst_n = 1'b0;
    #1;
    chk("t5_rst_en", 32'(fifo_wr_en), 32'd0);
    chk("t5_rst_data", 32'(fifo_data), 32'd0);
    chk("t5_rst_bursts", 32'(bursts_sent), 32'd0);
    chk("t5_rst_rdy", 32'(s_ready), 32'd0);
    step();
    wr_rst_n = 1'b1;
    step();
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h82);
    send(8'h81, 0);
    send(8'h82, 1);
    wait_ready("t5_back_to_fill", 20);
    chk("t5_bursts", 32'(bursts_sent), 32'd1);

    // T6: lone partial word with no s_last
    wc = wr_count;
`ifdef FIFO_BURST_TIMEOUT_EN
    exp_q.push_back(8'h5A);
    send(8'h5A, 0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("t6_pre_tmo", 32'(fifo_wr_en), 32'd0);
    end
    wait_ready("t6_tmo_flush", 30);
    chk("t6_tmo_wr_cnt", 32'(wr_count), 32'(wc + 1));
    chk("t6_bursts", 32'(bursts_sent), 32'd2);
`else
    send(8'h5A, 0);
    for (int i = 0; i < 40; i++) begin
      step();
    end
    chk("t6_no_write", 32'(wr_count), 32'(wc));
    chk("t6_still_fill", 32'(s_ready), 32'd1);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h5B);
    send(8'h5B, 1);
    wait_ready("t6_back_to_fill", 20);
    chk("t6_wr_cnt", 32'(wr_count), 32'(wc + 2));
    chk("t6_bursts", 32'(bursts_sent), 32'd2);
`endif

    chk("final_done_cnt", 32'(done_cnt), 32'd8);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
